// File: rtl/runway_access_arbiter.sv
// Runway access arbiter: queues landing/takeoff requests and grants the single runway
// one aircraft at a time, blocking takeoffs in severe weather and locking down in emergencies.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | runway free, choose next grant (landings before takeoffs)
// GRANT    | one-cycle grant pulse, runway becomes occupied
// OCCUPIED | runway held until the hold counter reaches zero
// LOCKDOWN | weather emergency: landings only, takeoff slot held empty
module runway_access_arbiter #(
    parameter int QUEUE_DEPTH   = 4,
    parameter int OCCUPY_CYCLES = 8,
    parameter int ID_W          = 4
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 req_valid,
    input  logic                                 req_type,
    input  logic [ID_W-1:0]                      req_id,
    input  logic                                 severe_weather,
    input  logic                                 emergency_landing_alert,
    input  logic [1:0]                           weather_state,
    output logic                                 req_ack,
    output logic                                 req_nack,
    output logic                                 grant_valid,
    output logic                                 grant_type,
    output logic [ID_W-1:0]                      grant_id,
    output logic                                 runway_busy,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]     landing_count,
    output logic [1:0]                           arb_state
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int HW = $clog2(OCCUPY_CYCLES);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(OCCUPY_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        GRANT    = 2'b01,
        OCCUPIED = 2'b10,
        LOCKDOWN = 2'b11
    } state_t;

    state_t          state, state_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic [ID_W-1:0] fifo_mem [QUEUE_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            slot_valid;
    logic [ID_W-1:0] slot_id;

    logic            emergency, fifo_full, fifo_empty;
    logic            push, pop, take_accept;
    logic            slot_take, slot_clear, grant_load;
    logic            grant_type_nxt;
    logic [ID_W-1:0] grant_id_nxt;

    assign emergency  = emergency_landing_alert | (weather_state == 2'b11);
    assign fifo_full  = (landing_count == CW'(QUEUE_DEPTH));
    assign fifo_empty = (landing_count == '0);

    // Fullness uses the registered count, so a push into a full queue is refused even on a pop cycle.
    assign push        = req_valid & ~req_type & ~fifo_full;
    assign take_accept = req_valid & req_type & ~slot_valid & ~severe_weather
                         & ~emergency & (state != LOCKDOWN);

    assign grant_valid = (state == GRANT);
    assign runway_busy = (state == GRANT) | (state == OCCUPIED);
    assign arb_state   = state;

    always_comb begin
        state_nxt      = state;
        hold_nxt       = hold_cnt;
        pop            = 1'b0;
        slot_take      = 1'b0;
        slot_clear     = 1'b0;
        grant_load     = 1'b0;
        grant_type_nxt = 1'b0;
        grant_id_nxt   = fifo_mem[rd_ptr];
        case (state)
            IDLE: begin
                if (emergency) begin
                    slot_clear = 1'b1;
                    state_nxt  = LOCKDOWN;
                end else if (!fifo_empty) begin
                    pop        = 1'b1;
                    grant_load = 1'b1;
                    state_nxt  = GRANT;
                end else if (slot_valid && !severe_weather) begin
                    slot_take      = 1'b1;
                    grant_load     = 1'b1;
                    grant_type_nxt = 1'b1;
                    grant_id_nxt   = slot_id;
                    state_nxt      = GRANT;
                end
            end
            GRANT: begin
                hold_nxt  = HOLD_LOAD;
                state_nxt = OCCUPIED;
            end
            OCCUPIED: begin
                if (hold_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    hold_nxt = hold_cnt - HW'(1);
                end
            end
            LOCKDOWN: begin
                // After a lockdown grant the FSM passes through IDLE, which re-checks the emergency.
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    grant_load = 1'b1;
                    state_nxt  = GRANT;
                end else if (!emergency) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= req_id;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            landing_count <= '0;
            slot_valid    <= 1'b0;
            slot_id       <= '0;
            req_ack       <= 1'b0;
            req_nack      <= 1'b0;
            grant_type    <= 1'b0;
            grant_id      <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            req_ack  <= push | take_accept;
            req_nack <= req_valid & ~(push | take_accept);

            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   landing_count <= landing_count + CW'(1);
                2'b01:   landing_count <= landing_count - CW'(1);
                default: landing_count <= landing_count;
            endcase

            if (slot_take || slot_clear) begin
                slot_valid <= 1'b0;
            end else if (take_accept) begin
                slot_valid <= 1'b1;
                slot_id    <= req_id;
            end

            if (grant_load) begin
                grant_type <= grant_type_nxt;
                grant_id   <= grant_id_nxt;
            end
        end
    end

endmodule

// File: doc/runway_access_arbiter.md
Name: runway_access_arbiter

Overview:
- Consumer of the weather control unit outputs: severe_weather, emergency_landing_alert and the 2-bit weather state.
- Accepts landing and takeoff requests from the radio interface, queues them, and grants the single runway one aircraft at a time.
- Blocks takeoffs in severe weather and enters lockdown, landings only, during weather emergencies.

Parameters:
- QUEUE_DEPTH, 4, landing FIFO entries (power of two, >=2)
- OCCUPY_CYCLES, 8, runway hold time per grant in cycles (>=2)
- ID_W, 4, aircraft ID width

Ports:
- CLK  in  1  clock, rising-edge
- RST  in  1  reset, asynchronous, active-high
- req_valid  in  1  request strobe, one cycle per request
- req_type  in  1  0=landing, 1=takeoff
- req_id  in  ID_W  aircraft ID
- severe_weather  in  1  from weather unit
- emergency_landing_alert  in  1  from weather unit
- weather_state  in  2  weather unit state; 2'b11 = emergency
- req_ack  out  1  request accepted (1-cycle pulse)
- req_nack  out  1  request rejected (1-cycle pulse)
- grant_valid  out  1  runway grant (1-cycle pulse)
- grant_type  out  1  type of granted request
- grant_id  out  ID_W  ID of granted aircraft
- runway_busy  out  1  runway occupied
- landing_count  out  $clog2(QUEUE_DEPTH+1)  landing FIFO occupancy
- arb_state  out  2  FSM state

Behaviour:
- Reset: all outputs 0, FIFO empty, takeoff slot empty, FSM IDLE, hold counter 0. RST mid-operation aborts everything immediately; the runway is freed.
- Signal emergency = emergency_landing_alert | (weather_state==2'b11).
- Request acceptance: ack/nack registered, one cycle after req_valid. Exactly one of the two pulses per request.
  - Landing: accepted and pushed if the FIFO is not full, else nack. Fullness is evaluated before any same-cycle pop, so a push into a full FIFO during a pop is nacked.
  - Takeoff: accepted into the single takeoff slot only if the slot is empty, severe_weather=0 and emergency=0; else nack.
- FSM (arb_state encoding):
  - IDLE (00):
    - emergency -> LOCKDOWN; the takeoff slot is cleared in the same cycle.
    - else FIFO non-empty -> pop head, GRANT landing.
    - else slot valid and severe_weather=0 -> clear slot, GRANT takeoff.
    - else stay.
    - Landings always have priority over takeoffs.
  - GRANT (01): exactly one cycle.
    - grant_valid=1; grant_id/grant_type hold the popped or slotted request.
    - Load hold counter with OCCUPY_CYCLES-2, go to OCCUPIED.
  - OCCUPIED (10): counter decrements each cycle; at counter==0 -> IDLE next cycle.
  - LOCKDOWN (11):
    - Slot held empty; all takeoff requests nacked.
    - FIFO non-empty -> pop, GRANT landing.
    - emergency=0 -> IDLE.
    - After that grant completes, the FSM returns via IDLE, which re-enters LOCKDOWN if emergency persists.
- runway_busy=1 in GRANT and OCCUPIED: exactly OCCUPY_CYCLES cycles per grant, starting on the grant_valid cycle. Grants are never closer than OCCUPY_CYCLES+1 cycles apart.
- grant_id/grant_type hold their last value between grants; only grant_valid qualifies them.
- A pending takeoff is held, not granted, while severe_weather=1. It is granted once severe_weather clears, provided the FIFO is empty.
- Emergency asserting during GRANT/OCCUPIED does not shorten occupancy. LOCKDOWN is taken at the next IDLE evaluation.
- FIFO pointers wrap modulo QUEUE_DEPTH. landing_count is updated the cycle after push/pop; simultaneous push and pop leave it unchanged.
- Outputs registered; no combinational path from inputs to outputs.

Test Plan:
- After reset, landing id=3 at cycle 0 -> ack cycle 1. Then: grant_valid with id=3, type=0. runway_busy high 8 cycles. landing_count returns 0.
- Pending takeoff id=5 plus 5 landings id=1..5 while runway busy -> 4 acks, 5th landing nacked (depth 4). Landings granted in order 1,2,3,4 at 9-cycle spacing, then takeoff id=5.
- Takeoff id=7 with severe_weather=1 -> nack, no grant. Takeoff accepted with weather clear, then severe_weather rises before grant -> held until severe_weather falls, then granted.
- Weather_state=2'b11 with takeoff id=2 pending and landing id=9 queued -> arb_state=11, takeoff slot cleared, landing 9 granted. New takeoff nacked. Emergency clears -> arb_state returns 00.
- Full FIFO with a pop in the same cycle as a landing request -> nack. landing_count stays consistent; pointer wrap verified over 10 push/pop pairs.
- RST pulse mid-OCCUPIED with 2 landings queued -> runway_busy=0, landing_count=0, arb_state=00 immediately. No grant until a new request arrives.
